alu_client: RTL and testbench

Initiator-side controller for the 8-bit registered ALU (2-bit op, 8-bit a/b, 8-bit y, one-cycle registered result, y reset to 0).
- Accepts tagged operation requests over a valid/ready channel and drives the ALU operand/op port.
- Captures y at the correct cycle and checks it against a built-in golden model.
- Returns tagged results through a buffered valid/ready response channel.
- Sits between the command source (sequencer or CPU-side decoder) and the ALU instance.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_resp_fifo.sv | 54 +++++
 rtl/alu_client.sv | 127 ++++++++++++
 tb/tb_alu_client.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit registered ALU, its initiator-side client and the bench.
// Holds the opcode encoding, the result latency and the golden arithmetic model.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    localparam int ALU_LAT = 1;

    // All results are taken modulo 2^8: carry and borrow are dropped.
    function automatic logic [7:0] alu_golden(input alu_op_e op,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
        logic [7:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            default: r = a | b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// Synchronous response FIFO with a combinational head (first-word fall-through).
// The head payload reads as zero while the FIFO is empty so outputs are clean after reset.
module alu_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         do_push;
    logic         do_pop;

    // The extra pointer bit separates full from empty when the indices coincide.
    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_client.sv
// Initiator-side ALU controller: issues tagged requests to a one-cycle registered ALU,
// checks each result against the golden model and queues tagged responses.
module alu_client
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [1:0]       alu_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_y,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_y,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic [7:0]       err_count
);

    localparam int PW = 8 + TAG_W + 1;
    localparam int CW = $clog2(DEPTH);

    logic             accept;
    logic             s1_v_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic [7:0]       s1_gold_reg;
    logic             s2_v_reg;
    logic [TAG_W-1:0] s2_tag_reg;
    logic [7:0]       s2_gold_reg;
    logic [7:0]       err_count_reg;

    logic             push;
    logic             push_err;
    logic [PW-1:0]    push_data;
    logic             pop;
    logic [PW-1:0]    pop_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW:0]      fifo_count;
    logic [CW+1:0]    used;

    // Every accepted request owns a FIFO slot from issue onwards, so a push never meets a full FIFO.
    assign used      = {1'b0, fifo_count}
                     + {{(CW+1){1'b0}}, s1_v_reg}
                     + {{(CW+1){1'b0}}, s2_v_reg};
    assign req_ready = !fifo_full && (used < (CW+2)'(DEPTH));
    assign accept    = req_valid && req_ready;

    // Operands hold their last accepted values between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= 2'b00;
            alu_a  <= 8'h00;
            alu_b  <= 8'h00;
        end else if (accept) begin
            alu_op <= req_op;
            alu_a  <= req_a;
            alu_b  <= req_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg    <= 1'b0;
            s1_tag_reg  <= '0;
            s1_gold_reg <= 8'h00;
            s2_v_reg    <= 1'b0;
            s2_tag_reg  <= '0;
            s2_gold_reg <= 8'h00;
        end else begin
            s1_v_reg <= accept;
            if (accept) begin
                s1_tag_reg  <= req_tag;
                s1_gold_reg <= alu_golden(alu_op_e'(req_op), req_a, req_b);
            end
            s2_v_reg    <= s1_v_reg;
            s2_tag_reg  <= s1_tag_reg;
            s2_gold_reg <= s1_gold_reg;
        end
    end

    // Stage 2 lines up with the ALU's registered output for the same request.
    assign push      = s2_v_reg;
    assign push_err  = (alu_y != s2_gold_reg);
    assign push_data = {alu_y, s2_tag_reg, push_err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= 8'h00;
        end else if (push && push_err && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'h01;
        end
    end

    assign err_count = err_count_reg;

    alu_resp_fifo #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign resp_valid = !fifo_empty;
    assign pop        = resp_valid && resp_ready;
    assign resp_y     = pop_data[PW-1 -: 8];
    assign resp_tag   = pop_data[TAG_W:1];
    assign resp_err   = pop_data[0];

endmodule

// File: tb/tb_alu_client.sv
// Directed bench for alu_client with a behavioural registered ALU attached to the issue port.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_client;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [7:0]       req_a = 8'h00;
    logic [7:0]       req_b = 8'h00;
    logic [TAG_W-1:0] req_tag = '0;
    logic [1:0]       alu_op;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [7:0]       alu_y;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [7:0]       resp_y;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;
    logic [7:0]       err_count;

    logic fault_zero = 1'b0;
    logic fault_inv  = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] model_y(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    // Registered ALU with fault hooks: forced zero or inverted result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          alu_y <= 8'h00;
        else if (fault_zero) alu_y <= 8'h00;
        else if (fault_inv)  alu_y <= ~model_y(alu_op, alu_a, alu_b);
        else                 alu_y <= model_y(alu_op, alu_a, alu_b);
    end

    alu_client #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
        .resp_tag(resp_tag), .resp_err(resp_err), .err_count(err_count)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b want 0", resp_valid); end
        checks++; if (alu_op !== 2'b00 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            errors++; $display("FAIL reset_alu_port: got op=%0h a=%0h b=%0h want 0 0 0", alu_op, alu_a, alu_b); end
        checks++; if (resp_y !== 8'h00 || resp_tag !== 4'h0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL reset_resp_payload: got y=%0h tag=%0h err=%0b want 0 0 0", resp_y, resp_tag, resp_err); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count: got %0h want 0", err_count); end
        rst_n = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_single_add();
        drive(2'b00, 8'h7F, 8'h01, 4'd3);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (alu_op !== 2'b00 || alu_a !== 8'h7F || alu_b !== 8'h01) begin
            errors++; $display("FAIL single_issue: got op=%0h a=%0h b=%0h want 0 7f 01", alu_op, alu_a, alu_b); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_e1: got %0b want 0", resp_valid); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_e2: got %0b want 0", resp_valid); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_y !== 8'h80 || resp_tag !== 4'd3 || resp_err !== 1'b0) begin
            errors++; $display("FAIL single_resp: got v=%0b y=%0h tag=%0h err=%0b want 1 80 3 0", resp_valid, resp_y, resp_tag, resp_err); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %0b want 0", resp_valid); end
        $display("single_add: 7f+01 tag 3 -> y=%0h", 8'h80);
    endtask

    task automatic test_wrap();
        logic [1:0] ops [4];
        logic [7:0] as [4];
        logic [7:0] bs [4];
        logic [7:0] ys [4];
        ops[0] = 2'b00; as[0] = 8'hFF; bs[0] = 8'h02; ys[0] = 8'h01;
        ops[1] = 2'b01; as[1] = 8'h00; bs[1] = 8'h01; ys[1] = 8'hFF;
        ops[2] = 2'b10; as[2] = 8'hF0; bs[2] = 8'h3C; ys[2] = 8'h30;
        ops[3] = 2'b11; as[3] = 8'hF0; bs[3] = 8'h0F; ys[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], as[i], bs[i], 4'(i + 4));
            tick();
        end
        req_valid = 1'b0;
        repeat (3) tick();
        checks++; if (alu_op !== 2'b11 || alu_a !== 8'hF0 || alu_b !== 8'h0F) begin
            errors++; $display("FAIL wrap_hold: got op=%0h a=%0h b=%0h want 3 f0 0f", alu_op, alu_a, alu_b); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_y !== ys[i] || resp_tag !== 4'(i + 4) || resp_err !== 1'b0) begin
                errors++; $display("FAIL wrap_resp%0d: got v=%0b y=%0h tag=%0h err=%0b want 1 %0h %0h 0",
                                   i, resp_valid, resp_y, resp_tag, resp_err, ys[i], i + 4);
            end
            $display("wrap: op=%0d a=%0h b=%0h -> y=%0h tag=%0h", ops[i], as[i], bs[i], resp_y, resp_tag);
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int acc;
        int got;
        acc = 0;
        resp_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            drive(2'b00, 8'(acc), 8'(acc), 4'(acc));
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", acc); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %0b want 0", req_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_tag !== 4'(i) || resp_y !== 8'(2 * i)) begin
                errors++; $display("FAIL bp_drain%0d: got v=%0b tag=%0h y=%0h want 1 %0h %0h", i, resp_valid, resp_tag, resp_y, i, 2 * i);
            end
            $display("backpressure drain: tag=%0h y=%0h", resp_tag, resp_y);
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty: got v=%0b ready=%0b want 0 1", resp_valid, req_ready); end
        // Sustained stream: ready must never drop with the consumer always accepting.
        got = 0;
        resp_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (resp_valid) begin
                checks++;
                if (resp_tag !== 4'(got) || resp_y !== 8'(got + 1)) begin
                    errors++; $display("FAIL stream_resp%0d: got tag=%0h y=%0h want %0h %0h", got, resp_tag, resp_y, got, got + 1);
                end
                got++;
            end
            if (cyc < 14) begin
                drive(2'b00, 8'(cyc), 8'h01, 4'(cyc));
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got 0 want 1", cyc); end
            end else begin
                req_valid = 1'b0;
            end
            tick();
        end
        resp_ready = 1'b0;
        checks++; if (got != 14) begin errors++; $display("FAIL stream_count: got %0d want 14", got); end
        $display("stream: %0d responses at 1 op/cycle", got);
    endtask

    task automatic test_fault();
        int acc;
        fault_zero = 1'b1;
        drive(2'b00, 8'h01, 8'h01, 4'd9);
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        checks++; if (resp_valid !== 1'b1 || resp_y !== 8'h00 || resp_tag !== 4'd9 || resp_err !== 1'b1) begin
            errors++; $display("FAIL fault_resp: got v=%0b y=%0h tag=%0h err=%0b want 1 00 9 1", resp_valid, resp_y, resp_tag, resp_err); end
        checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL fault_count1: got %0h want 01", err_count); end
        $display("fault: forced y=00 -> err=%0b err_count=%0h", resp_err, err_count);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        fault_zero = 1'b0;
        drive(2'b00, 8'h01, 8'h01, 4'd10);
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        checks++; if (resp_y !== 8'h02 || resp_err !== 1'b0 || err_count !== 8'h01) begin
            errors++; $display("FAIL fault_clean: got y=%0h err=%0b cnt=%0h want 02 0 01", resp_y, resp_err, err_count); end
        resp_ready = 1'b1;
        tick();
        // 300 further mismatches must saturate the counter.
        fault_inv = 1'b1;
        acc = 0;
        for (int cyc = 0; cyc < 320; cyc++) begin
            if (acc < 300) begin
                drive(2'b00, 8'(cyc), 8'h00, 4'(cyc));
                if (req_ready) acc++;
            end else begin
                req_valid = 1'b0;
            end
            tick();
        end
        fault_inv = 1'b0;
        resp_ready = 1'b0;
        checks++; if (acc != 300) begin errors++; $display("FAIL fault_accepts: got %0d want 300", acc); end
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL fault_saturate: got %0h want ff", err_count); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL fault_drained: got %0b want 0", resp_valid); end
        $display("fault: %0d forced errors -> err_count=%0h", acc, err_count);
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 8'(i), 8'h00, 4'(i));
            tick();
        end
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_pre: got v=%0b ready=%0b want 1 0", resp_valid, req_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_now: got v=%0b ready=%0b want 0 1", resp_valid, req_ready); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL midrst_count: got %0h want 0", err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d: got 1 want 0", i); end
        end
        drive(2'b00, 8'h10, 8'h20, 4'hA);
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        checks++; if (resp_valid !== 1'b1 || resp_y !== 8'h30 || resp_tag !== 4'hA) begin
            errors++; $display("FAIL midrst_after: got v=%0b y=%0h tag=%0h want 1 30 a", resp_valid, resp_y, resp_tag); end
        $display("reset_mid: recovered, y=%0h tag=%0h", resp_y, resp_tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_concurrent();
        logic [3:0] q [$];
        logic [1:0] hist;
        logic [3:0] next_tag;
        logic       exp_ready;
        logic       acc;
        int         pops;
        resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(2'b00, 8'(i), 8'h00, 4'(i));
            q.push_back(4'(i));
            tick();
        end
        req_valid = 1'b0;
        repeat (3) tick();
        hist = 2'b00;
        next_tag = 4'd2;
        pops = 0;
        // Pop exactly when a push lands so FIFO occupancy stays at 2.
        for (int cyc = 0; cyc < 20; cyc++) begin
            exp_ready = (2 + int'(hist[0]) + int'(hist[1])) < DEPTH;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL conc_ready%0d: got %0b want %0b", cyc, req_ready, exp_ready); end
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL conc_valid%0d: got %0b want 1", cyc, resp_valid); end
            resp_ready = hist[1];
            if (resp_ready) begin
                checks++; if (resp_tag !== q[0]) begin errors++; $display("FAIL conc_tag%0d: got %0h want %0h", cyc, resp_tag, q[0]); end
                $display("concurrent: pop tag=%0h", resp_tag);
                void'(q.pop_front());
                pops++;
            end
            drive(2'b00, {4'h0, next_tag}, 8'h00, next_tag);
            acc = req_ready;
            if (acc) begin
                q.push_back(next_tag);
                next_tag = next_tag + 4'd1;
            end
            tick();
            hist = {hist[0], acc};
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 8 && resp_valid; i++) begin
            checks++; if (q.size() == 0 || resp_tag !== q[0]) begin
                errors++; $display("FAIL conc_drain%0d: got %0h want %0h", i, resp_tag, (q.size() != 0) ? q[0] : 4'h0); end
            if (q.size() != 0) void'(q.pop_front());
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
        checks++; if (q.size() != 0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL conc_leftover: got %0d tags outstanding, v=%0b want 0 0", q.size(), resp_valid); end
        checks++; if (pops < 10) begin errors++; $display("FAIL conc_pops: got %0d want >=10", pops); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_add();
        test_wrap();
        test_backpressure();
        test_fault();
        test_reset_mid();
        test_concurrent();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
